// File: rtl/rs_issue_scheduler.sv
// Issue scheduler between one reservation station and a multi-cycle,
// non-pipelined functional unit. Picks the oldest ready entry by ROB age,
// offers it to the FU, tracks it through execution and presents its ROB tag
// for writeback. Work younger than a flush point is squashed.
//
// state | meaning
// IDLE  | nothing held; looking for the oldest ready candidate
// ISSUE | selected op offered to the FU, waiting for issue_ready
// EXEC  | FU busy with the accepted op, counter running down
// DONE  | result tag offered for writeback, waiting for done_ready
module rs_issue_scheduler #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 3,
  parameter int FU_LATENCY  = 3,
  localparam int IDX_W      = $clog2(NUM_ENTRIES),
  localparam int CNT_W      = (FU_LATENCY > 1) ? $clog2(FU_LATENCY) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_ENTRIES-1:0]       entry_ready,
  input  logic [NUM_ENTRIES*TAG_W-1:0] entry_rob_tag,
  input  logic [TAG_W-1:0]             rob_head,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [IDX_W-1:0]             issue_idx,
  output logic [TAG_W-1:0]             issue_tag,
  output logic [NUM_ENTRIES-1:0]       entry_clear,
  output logic                         fu_busy,
  output logic                         done_valid,
  input  logic                         done_ready,
  output logic [TAG_W-1:0]             done_tag,
  input  logic                         flush,
  input  logic [TAG_W-1:0]             flush_tag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   sel_idx, sel_idx_n;
  logic [TAG_W-1:0]   sel_tag, sel_tag_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic [TAG_W-1:0]   flush_age;
  logic [TAG_W-1:0]   sel_age;
  logic               squash;
  logic               accept;

  logic               any_cand;
  logic [IDX_W-1:0]   best_idx;
  logic [TAG_W-1:0]   best_tag;
  logic [TAG_W-1:0]   best_age;
  logic [TAG_W-1:0]   cur_tag;
  logic [TAG_W-1:0]   cur_age;
  logic               cur_cand;

  // Ages wrap modulo 2**TAG_W, so plain subtraction at TAG_W width is enough.
  assign flush_age = flush_tag - rob_head;
  assign sel_age   = sel_tag - rob_head;

  // The held op is killed when a flush names an older instruction.
  assign squash = flush && (state != IDLE) && (sel_age > flush_age);

  assign issue_valid = (state == ISSUE) && !squash;
  assign accept      = issue_valid && issue_ready;
  assign entry_clear = accept ? (NUM_ENTRIES'(1) << sel_idx) : '0;
  assign done_valid  = (state == DONE) && !squash;

  assign issue_idx = sel_idx;
  assign issue_tag = sel_tag;
  assign done_tag  = sel_tag;

  // Oldest-candidate search; strict less-than keeps the lowest index on ties.
  always_comb begin
    any_cand = 1'b0;
    best_idx = '0;
    best_tag = '0;
    best_age = '0;
    cur_tag  = '0;
    cur_age  = '0;
    cur_cand = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cur_tag  = entry_rob_tag[i*TAG_W +: TAG_W];
      cur_age  = cur_tag - rob_head;
      cur_cand = entry_ready[i] && !(flush && (cur_age > flush_age));
      if (cur_cand && (!any_cand || (cur_age < best_age))) begin
        any_cand = 1'b1;
        best_idx = IDX_W'(i);
        best_tag = cur_tag;
        best_age = cur_age;
      end
    end
  end

  // Next-state logic; a squash overrides every other transition.
  always_comb begin
    state_n   = state;
    sel_idx_n = sel_idx;
    sel_tag_n = sel_tag;
    cnt_n     = cnt;
    case (state)
      IDLE: begin
        if (any_cand) begin
          state_n   = ISSUE;
          sel_idx_n = best_idx;
          sel_tag_n = best_tag;
        end
      end
      ISSUE: begin
        if (squash) begin
          state_n = IDLE;
        end else if (accept) begin
          state_n = (FU_LATENCY == 1) ? DONE : EXEC;
          cnt_n   = CNT_W'(FU_LATENCY - 1);
        end
      end
      EXEC: begin
        if (squash) begin
          state_n = IDLE;
        end else begin
          // Leaving on the cycle the count reaches zero gives DONE exactly
          // FU_LATENCY cycles after accept.
          cnt_n = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        if (squash || (done_valid && done_ready)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and held-op registers; fu_busy is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel_idx <= '0;
      sel_tag <= '0;
      cnt     <= '0;
      fu_busy <= 1'b0;
    end else begin
      state   <= state_n;
      sel_idx <= sel_idx_n;
      sel_tag <= sel_tag_n;
      cnt     <= cnt_n;
      fu_busy <= (state_n == EXEC) || (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench for rs_issue_scheduler: expected issues and completions
// are queued as stimulus is applied and checked when handshakes occur.
module tb_rs_issue_scheduler;

  localparam int N   = 4;
  localparam int TW  = 3;
  localparam int IW  = 2;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  entry_ready;
  logic [N*TW-1:0] entry_rob_tag;
  logic [TW-1:0] rob_head;
  logic          issue_valid;
  logic          issue_ready;
  logic [IW-1:0] issue_idx;
  logic [TW-1:0] issue_tag;
  logic [N-1:0]  entry_clear;
  logic          fu_busy;
  logic          done_valid;
  logic          done_ready;
  logic [TW-1:0] done_tag;
  logic          flush;
  logic [TW-1:0] flush_tag;

  rs_issue_scheduler #(
    .NUM_ENTRIES(N),
    .TAG_W(TW),
    .FU_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .entry_ready(entry_ready),
    .entry_rob_tag(entry_rob_tag),
    .rob_head(rob_head),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_idx(issue_idx),
    .issue_tag(issue_tag),
    .entry_clear(entry_clear),
    .fu_busy(fu_busy),
    .done_valid(done_valid),
    .done_ready(done_ready),
    .done_tag(done_tag),
    .flush(flush),
    .flush_tag(flush_tag)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_done = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int q_idx[$];
  int q_tag[$];
  int q_done[$];
  int ei, et, ed, nd;
  bit gap_arm = 1'b0;
  bit gap_en  = 1'b0;
  logic prev_iv = 1'b0;
  logic prev_dv = 1'b0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tag(input int i, input int t);
    entry_rob_tag[i*TW +: TW] = TW'(t);
  endtask

  task automatic push_issue(input int idx, input int tag);
    q_idx.push_back(idx);
    q_tag.push_back(tag);
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while ((q_idx.size() + q_done.size()) != 0 && n < max) begin
      tick();
      n++;
    end
    chk(name, q_idx.size() + q_done.size(), 0);
  endtask

  task automatic wait_iv(input string name, input int max);
    int n = 0;
    while (!issue_valid && n < max) begin
      tick();
      n++;
    end
    chk(name, issue_valid, 1);
  endtask

  task automatic wait_busy(input string name, input int max);
    int n = 0;
    while (!fu_busy && n < max) begin
      tick();
      n++;
    end
    chk(name, fu_busy, 1);
  endtask

  always @(posedge clk) cyc++;

  // Handshake monitor: pops the scoreboard and models the RS freeing entries.
  always @(negedge clk) begin
    if (!reset) begin
      if (issue_valid && issue_ready) begin
        chk("issue_pending", q_idx.size() != 0, 1);
        if (q_idx.size() != 0) begin
          ei = q_idx.pop_front();
          et = q_tag.pop_front();
          chk("issue_idx", issue_idx, ei);
          chk("issue_tag", issue_tag, et);
          chk("entry_clear", entry_clear, 1 << ei);
        end
        acc_cyc = cyc;
      end else if (entry_clear != '0) begin
        chk("clear_no_accept", entry_clear, 0);
      end
      if (done_valid && !prev_dv) chk("latency", cyc - acc_cyc, LAT);
      if (issue_valid && !prev_iv && gap_en) begin
        chk("done_to_issue_gap", cyc - done_cyc, 2);
        gap_en = 1'b0;
      end
      if (done_valid && done_ready) begin
        chk("done_pending", q_done.size() != 0, 1);
        if (q_done.size() != 0) begin
          ed = q_done.pop_front();
          chk("done_tag", done_tag, ed);
        end
        done_cyc = cyc;
        n_done++;
        if (gap_arm) begin
          gap_en  = 1'b1;
          gap_arm = 1'b0;
        end
      end
      entry_ready = entry_ready & ~entry_clear;
    end
    prev_iv = issue_valid;
    prev_dv = done_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    entry_ready   = '0;
    entry_rob_tag = '0;
    rob_head      = '0;
    issue_ready   = 1'b0;
    done_ready    = 1'b0;
    flush         = 1'b0;
    flush_tag     = '0;
    repeat (3) tick();

    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_fu_busy", fu_busy, 0);
    chk("rst_entry_clear", entry_clear, 0);
    chk("rst_issue_idx", issue_idx, 0);
    chk("rst_issue_tag", issue_tag, 0);
    chk("rst_done_tag", done_tag, 0);
    reset = 1'b0;
    tick();

    // Ordering: entry 2 (tag 6, age 1) before entry 0 (tag 7, age 2).
    issue_ready = 1'b1;
    done_ready  = 1'b1;
    rob_head    = 3'd5;
    set_tag(0, 7);
    set_tag(2, 6);
    push_issue(2, 6);
    push_issue(0, 7);
    q_done.push_back(6);
    q_done.push_back(7);
    entry_ready = 4'b0101;
    tick();
    chk("issue_start", issue_valid, 1);
    wait_drain("order_drain", 60);

    // Wrap: head 6, tag 7 (age 1) before tag 1 (age 3).
    rob_head = 3'd6;
    set_tag(1, 1);
    set_tag(3, 7);
    push_issue(3, 7);
    push_issue(1, 1);
    q_done.push_back(7);
    q_done.push_back(1);
    entry_ready = 4'b1010;
    wait_drain("wrap_drain", 60);

    // Backpressure; entry_ready also drops while the offer is held.
    issue_ready = 1'b0;
    rob_head    = 3'd0;
    set_tag(1, 2);
    push_issue(1, 2);
    q_done.push_back(2);
    entry_ready = 4'b0010;
    wait_iv("bp_offer", 20);
    entry_ready = 4'b0000;
    repeat (4) begin
      tick();
      chk("bp_valid", issue_valid, 1);
      chk("bp_idx", issue_idx, 1);
      chk("bp_tag", issue_tag, 2);
      chk("bp_clear", entry_clear, 0);
    end
    issue_ready = 1'b1;
    wait_drain("bp_drain", 40);

    // Latency and done-to-next-issue spacing with back-to-back work.
    rob_head = 3'd0;
    set_tag(0, 1);
    set_tag(1, 2);
    push_issue(0, 1);
    push_issue(1, 2);
    q_done.push_back(1);
    q_done.push_back(2);
    gap_arm = 1'b1;
    entry_ready = 4'b0011;
    wait_drain("lat_drain", 60);
    chk("gap_checked", gap_arm | gap_en, 0);

    // Flush older than the in-flight op (tag 4 vs flush tag 2): squashed.
    rob_head = 3'd0;
    set_tag(2, 4);
    push_issue(2, 4);
    entry_ready = 4'b0100;
    wait_busy("fl_busy", 20);
    nd = n_done;
    flush     = 1'b1;
    flush_tag = 3'd2;
    #1;
    chk("fl_done_masked", done_valid, 0);
    tick();
    flush = 1'b0;
    chk("fl_idle", fu_busy, 0);
    repeat (6) tick();
    chk("fl_no_done", n_done, nd);
    chk("fl_no_issue", issue_valid, 0);
    wait_drain("fl_drain", 5);

    // Flush younger than the in-flight op (flush tag 5): no effect.
    push_issue(2, 4);
    q_done.push_back(4);
    entry_ready = 4'b0100;
    wait_busy("fl5_busy", 20);
    flush     = 1'b1;
    flush_tag = 3'd5;
    tick();
    flush = 1'b0;
    chk("fl5_still_busy", fu_busy, 1);
    wait_drain("fl5_drain", 30);

    // Flush colliding with accept: offer masked, no clear, back to IDLE.
    issue_ready = 1'b0;
    rob_head    = 3'd0;
    set_tag(1, 3);
    entry_ready = 4'b0010;
    wait_iv("col_offer", 20);
    issue_ready = 1'b1;
    flush       = 1'b1;
    flush_tag   = 3'd1;
    entry_ready = 4'b0000;
    #1;
    chk("col_iv_masked", issue_valid, 0);
    chk("col_no_clear", entry_clear, 0);
    tick();
    flush = 1'b0;
    chk("col_idle_iv", issue_valid, 0);
    chk("col_idle_busy", fu_busy, 0);
    repeat (3) tick();
    chk("col_stays_idle", issue_valid, 0);

    // Reset mid-operation abandons the op; no completion follows.
    done_ready = 1'b0;
    set_tag(0, 5);
    push_issue(0, 5);
    entry_ready = 4'b0001;
    wait_busy("rst_mid_busy", 20);
    nd = n_done;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy_cleared", fu_busy, 0);
    done_ready = 1'b1;
    repeat (8) tick();
    chk("rst_mid_no_done", n_done, nd);
    chk("rst_mid_no_dv", done_valid, 0);

    chk("queues_empty", q_idx.size() + q_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
